// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use, taken-branch and multi-cycle MUL hazard/stall control
//            for the 5-stage pipeline, with a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_is_mul,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   idex_write,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic                   exmem_bubble,
    output logic                   mul_start,
    output logic                   mul_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_MUL_LAST = 2'd2
    } state_t;

    // A 2-cycle MUL has no BUSY phase: the start cycle is its only stall.
    localparam logic [3:0] c_CNT_INIT = 4'(MUL_LATENCY - 2);
    localparam state_t     c_MUL_NEXT = (MUL_LATENCY == 2) ? ST_MUL_LAST : ST_MUL_BUSY;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic w_idle;
    logic w_load_use_raw;
    logic w_mul_enter;
    logic w_mul_stall;
    logic w_branch;
    logic w_load_use;

    // Detection is only live in IDLE and is suppressed while reset is held.
    assign w_idle         = (r_state == ST_IDLE) & ~reset;
    assign w_load_use_raw = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                            ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    assign w_mul_enter = w_idle & ex_is_mul;
    assign w_mul_stall = w_mul_enter | ((r_state == ST_MUL_BUSY) & ~reset);
    assign w_branch    = w_idle & ~ex_is_mul & ex_branch_taken;
    assign w_load_use  = w_idle & ~ex_is_mul & ~ex_branch_taken & w_load_use_raw;

    assign pc_write     = ~(w_mul_stall | w_load_use);
    assign ifid_write   = ~(w_mul_stall | w_load_use);
    assign idex_write   = ~w_mul_stall;
    assign idex_bubble  = w_branch | w_load_use;
    assign ifid_flush   = w_branch;
    assign exmem_bubble = w_mul_stall;
    assign mul_start    = w_mul_enter;
    assign mul_busy     = (r_state != ST_IDLE);
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_is_mul) begin
                        r_state <= c_MUL_NEXT;
                        r_cnt   <= c_CNT_INIT;
                    end
                end
                ST_MUL_BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_MUL_LAST;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_MUL_LAST: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!pc_write && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS-style core. It sits beside the decode-stage control unit and watches the ID and EX stages. It produces the PC/IF-ID write enables, the bubble and flush strobes, and the start pulse for the multi-cycle multiplier. It resolves three hazards: load-use stalls, taken-branch flushes, and multi-cycle MUL occupancy of EX. A saturating stall counter is provided for performance measurement.

## Interface
- MUL_LATENCY, 4, number of cycles a MUL occupies EX; legal range 2–15.
- STALL_CNT_W, 16, width of the stall-cycle counter.

- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- id_valid  input  1  a valid instruction is in ID
- id_rs  input  5  rs field of the ID instruction
- id_rt  input  5  rt field of the ID instruction
- id_uses_rt  input  1  the ID instruction reads rt (R-type, BEQ, SW)
- ex_mem_read  input  1  the EX instruction is LW
- ex_rd  input  5  destination register of the EX instruction
- ex_is_mul  input  1  the EX instruction is MUL
- ex_branch_taken  input  1  BEQ in EX resolved as taken
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID register write enable
- idex_write  output  1  ID/EX register write enable (0 = hold)
- idex_bubble  output  1  load zeroed control into ID/EX
- ifid_flush  output  1  clear IF/ID to a NOP
- exmem_bubble  output  1  load zeroed control into EX/MEM
- mul_start  output  1  one-cycle start pulse to the multiplier
- mul_busy  output  1  FSM is not in IDLE
- stall_cycles  output  STALL_CNT_W  saturating count of cycles with pc_write=0

## Operation
- FSM states are IDLE, MUL_BUSY and MUL_LAST. There is a 4-bit down-counter, cnt.
- **Load-use** (combinational, IDLE only)
  - Detected when id_valid & ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Response: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1.
  - Lasts exactly one cycle; the condition clears naturally as the LW advances.
- **Taken branch** (combinational, IDLE only)
  - Response: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Overrides load-use in the same cycle.
- **MUL sequencing**
  - IDLE & ex_is_mul:
    - Asserts mul_start=1, pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
    - Next state is MUL_LAST if MUL_LATENCY==2; otherwise MUL_BUSY with cnt←MUL_LATENCY-2.
  - MUL_BUSY: same stall outputs, with mul_start=0. If cnt==1, next state is MUL_LAST; otherwise cnt←cnt-1.
  - MUL_LAST:
    - No stall; the pipeline advances and the MUL moves to MEM.
    - ex_is_mul is ignored. Load-use and branch detection are also off, because EX holds the MUL.
    - Next state is IDLE.
- Load-use and branch conditions cannot coincide with ex_is_mul, since they concern different EX instructions. If they do, ex_is_mul has priority.
- **Stall counter**: stall_cycles increments on each cycle with pc_write=0 and saturates at all-ones.
- **Default outputs** when no hazard is active: pc_write=1, ifid_write=1, idex_write=1; all bubble, flush and start outputs 0.

## Timing
- Reset values: state=IDLE, cnt=0, stall_cycles=0.
- While reset is high, all outputs take the IDLE defaults with detection disabled: pc_write=1, ifid_write=1, idex_write=1, idex_bubble=0, ifid_flush=0, exmem_bubble=0, mul_start=0, mul_busy=0.
- Reset mid-MUL: the FSM returns to IDLE asynchronously and stalls drop immediately.
- Load-use and branch outputs are combinational (0-cycle latency from the inputs). FSM transitions occur on the rising clk edge.
- For a MUL entering EX at cycle T0:
  - Stall is asserted during T0 … T0+MUL_LATENCY-2, i.e. MUL_LATENCY-1 cycles.
  - mul_start is high only in T0.
  - mul_busy is high during T0+1 … T0+MUL_LATENCY-1.
  - Back-to-back MULs: the second MUL enters EX at T0+MUL_LATENCY (state is IDLE again) and is sequenced fresh.

## Test plan
- **Load-use:** LW with ex_rd=5; ID instruction has id_rs=5 -> exactly one cycle of pc_write=0, idex_bubble=1; stall_cycles=1.
- **No false hazard:** ex_rd=0 with ex_mem_read=1 and id_rs=0 -> no stall. Also, id_rt=5 with id_uses_rt=0 -> no stall.
- **Taken branch:** ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1 for one cycle.
- **MUL at default latency:** ex_is_mul held high with MUL_LATENCY=4 ->
  - mul_start in T0 only;
  - pc_write=0 for T0–T2 and pc_write=1 at T3;
  - no retrigger at T3;
  - stall_cycles=3.
- **MUL at minimum latency:** MUL_LATENCY=2 -> one stall cycle, then MUL_LAST, then IDLE.
- **Reset mid-MUL and counter saturation:**
  - Assert reset at T1 of a MUL -> state IDLE, mul_busy=0 and pc_write=1 immediately.
  - Force STALL_CNT_W=4 and exceed 15 stall cycles -> stall_cycles holds at 15.
